// File: rtl/irom_pkg.sv
// Shared constants, types and address-check helper for the instruction ROM arbiter.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package irom_pkg;

    localparam int unsigned IROM_ADDR_BITS = 20;
    localparam logic [31:0] IROM_BASE_ADDR = 32'h1c00_0000;

    localparam int PORT_IF = 0;
    localparam int PORT_D  = 1;

    // One per-port response slot.
    typedef struct packed {
        logic        valid;
        logic        err;
        logic [31:0] data;
    } resp_t;

    // off is addr - base taken modulo 2**32, so an address below the base
    // wraps to a huge offset and falls out of range naturally.
    function automatic logic addr_err(input logic [31:0] addr,
                                      input logic [31:0] off,
                                      input int unsigned abits);
        logic [32:0] lim;
        lim = 33'd4 << abits;
        return (addr[1:0] != 2'b00) || ({1'b0, off} >= lim);
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: a lone requester wins, a tie goes to the port not granted last.
// Latency: grant is combinational from req; the last-grant flop updates on the edge.
// Backpressure: none of its own; callers mask req with their own readiness.
module rr_arb2 (
    input  logic       clk,
    input  logic       rstn,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);

    // last_q holds the index of the most recently granted port; resets to 1
    // so the very first tie goes to port 0.
    logic last_q;
    logic last_d;

    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = last_q ? 2'b01 : 2'b10;
        end
        last_d = last_q;
        if (advance) begin
            last_d = gnt[1];
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/irom_arbiter.sv
// Shares one combinational instruction ROM between fetch (port 0) and data (port 1) requesters.
// Latency: 1 cycle from accepted request to resp_valid; 1 word/cycle aggregate throughput.
// Backpressure: a port is only granted when its response slot is empty or draining; if_flush blocks port 0.
// Ports: clk/rstn (sync active-low); if_* fetch req/resp + if_flush; d_* data req/resp; rom_a/rom_spo to the ROM.
module irom_arbiter
    import irom_pkg::*;
#(
    parameter int unsigned ADDR_BITS = IROM_ADDR_BITS,
    parameter logic [31:0] BASE_ADDR = IROM_BASE_ADDR
) (
    input  logic                 clk,
    input  logic                 rstn,

    input  logic                 if_req_valid,
    output logic                 if_req_ready,
    input  logic [31:0]          if_req_addr,
    output logic                 if_resp_valid,
    input  logic                 if_resp_ready,
    output logic [31:0]          if_resp_data,
    output logic                 if_resp_err,
    input  logic                 if_flush,

    input  logic                 d_req_valid,
    output logic                 d_req_ready,
    input  logic [31:0]          d_req_addr,
    output logic                 d_resp_valid,
    input  logic                 d_resp_ready,
    output logic [31:0]          d_resp_data,
    output logic                 d_resp_err,

    output logic [ADDR_BITS-1:0] rom_a,
    input  logic [31:0]          rom_spo
);

    resp_t       if_q, if_d;
    resp_t       d_q,  d_d;
    logic [1:0]  req;
    logic [1:0]  gnt;
    logic [31:0] addr_sel;
    logic [31:0] off;
    logic        err_sel;

    // A slot being drained this cycle can take a new word on the same edge.
    // Gating with rstn keeps req_ready low while reset is held.
    assign req[PORT_IF] = rstn && if_req_valid && !if_flush
                          && (!if_q.valid || if_resp_ready);
    assign req[PORT_D]  = rstn && d_req_valid
                          && (!d_q.valid || d_resp_ready);

    rr_arb2 u_arb (
        .clk     (clk),
        .rstn    (rstn),
        .req     (req),
        .advance (|req),
        .gnt     (gnt)
    );

    assign if_req_ready = gnt[PORT_IF];
    assign d_req_ready  = gnt[PORT_D];

    // With no grant the mux defaults to the fetch address; rom_a is then a don't-care.
    assign addr_sel = gnt[PORT_D] ? d_req_addr : if_req_addr;
    assign off      = addr_sel - BASE_ADDR;
    assign rom_a    = off[ADDR_BITS+1:2];
    assign err_sel  = addr_err(addr_sel, off, ADDR_BITS);

    always_comb begin
        if_d = if_q;
        if (if_resp_ready || if_flush) begin
            if_d.valid = 1'b0;
        end
        if (gnt[PORT_IF]) begin
            if_d.valid = 1'b1;
            if_d.err   = err_sel;
            if_d.data  = err_sel ? 32'h0 : rom_spo;
        end

        d_d = d_q;
        if (d_resp_ready) begin
            d_d.valid = 1'b0;
        end
        if (gnt[PORT_D]) begin
            d_d.valid = 1'b1;
            d_d.err   = err_sel;
            d_d.data  = err_sel ? 32'h0 : rom_spo;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            if_q <= '0;
            d_q  <= '0;
        end else begin
            if_q <= if_d;
            d_q  <= d_d;
        end
    end

    assign if_resp_valid = if_q.valid;
    assign if_resp_err   = if_q.err;
    assign if_resp_data  = if_q.data;
    assign d_resp_valid  = d_q.valid;
    assign d_resp_err    = d_q.err;
    assign d_resp_data   = d_q.data;

endmodule

// File: tb/tb_irom_arbiter.sv
// Directed bench for irom_arbiter with a behavioural ROM (word k reads 0xA500_0000 ^ k).
// Latency: checks 1-cycle response latency and combinational ready/rom_a.
// Backpressure: exercises resp_ready stalls, flush and reset mid-transaction.
module tb_irom_arbiter;

    localparam logic [31:0] BASE = 32'h1c00_0000;

    logic        clk = 1'b0;
    logic        rstn;
    logic        if_req_valid, if_req_ready, if_resp_valid, if_resp_ready, if_resp_err, if_flush;
    logic [31:0] if_req_addr, if_resp_data;
    logic        d_req_valid, d_req_ready, d_resp_valid, d_resp_ready, d_resp_err;
    logic [31:0] d_req_addr, d_resp_data;
    logic [19:0] rom_a;
    logic [31:0] rom_spo;

    int n_chk  = 0;
    int n_fail = 0;

    irom_arbiter #(.ADDR_BITS(20), .BASE_ADDR(BASE)) dut (
        .clk           (clk),
        .rstn          (rstn),
        .if_req_valid  (if_req_valid),
        .if_req_ready  (if_req_ready),
        .if_req_addr   (if_req_addr),
        .if_resp_valid (if_resp_valid),
        .if_resp_ready (if_resp_ready),
        .if_resp_data  (if_resp_data),
        .if_resp_err   (if_resp_err),
        .if_flush      (if_flush),
        .d_req_valid   (d_req_valid),
        .d_req_ready   (d_req_ready),
        .d_req_addr    (d_req_addr),
        .d_resp_valid  (d_resp_valid),
        .d_resp_ready  (d_resp_ready),
        .d_resp_data   (d_resp_data),
        .d_resp_err    (d_resp_err),
        .rom_a         (rom_a),
        .rom_spo       (rom_spo)
    );

    always #5 clk = ~clk;

    assign rom_spo = 32'hA500_0000 ^ {12'h0, rom_a};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] err_addrs [3];

    initial begin
        err_addrs[0] = 32'h1c00_0002;
        err_addrs[1] = 32'h1bff_fffc;
        err_addrs[2] = 32'h1c40_0000;

        // Reset with requests present
        rstn = 1'b0; if_flush = 1'b0;
        if_req_valid = 1'b1; d_req_valid = 1'b1;
        if_req_addr = BASE; d_req_addr = BASE;
        if_resp_ready = 1'b1; d_resp_ready = 1'b1;
        tick();
        #1;
        check("rst_if_rdy", 32'(if_req_ready), 0);
        check("rst_d_rdy", 32'(d_req_ready), 0);
        tick();
        check("rst_if_vld", 32'(if_resp_valid), 0);
        check("rst_d_vld", 32'(d_resp_valid), 0);
        check("rst_if_dat", if_resp_data, 0);
        check("rst_if_err", 32'(if_resp_err), 0);
        rstn = 1'b1; if_req_valid = 1'b0; d_req_valid = 1'b0;
        tick();

        // Port 0 streaming words 0..3
        if_req_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if_req_addr = BASE + 32'(4 * k);
            #1;
            check("t1_rdy", 32'(if_req_ready), 1);
            check("t1_rom_a", 32'(rom_a), 32'(k));
            tick();
            check("t1_vld", 32'(if_resp_valid), 1);
            check("t1_dat", if_resp_data, 32'hA500_0000 ^ 32'(k));
            check("t1_err", 32'(if_resp_err), 0);
        end
        if_req_valid = 1'b0;
        tick();
        check("t1_drain", 32'(if_resp_valid), 0);

        // Lone data-port request, leaves last = port 1
        d_req_valid = 1'b1; d_req_addr = BASE + 32'h40;
        #1;
        check("t2p_rdy", 32'(d_req_ready), 1);
        check("t2p_rom_a", 32'(rom_a), 32'h10);
        tick();
        check("t2p_vld", 32'(d_resp_valid), 1);
        check("t2p_dat", d_resp_data, 32'hA500_0010);

        // Both saturated: grants alternate 0,1,0,1...
        if_req_valid = 1'b1; if_req_addr = BASE + 32'h100; d_req_addr = BASE + 32'h200;
        for (int i = 0; i < 6; i++) begin
            logic e0;
            e0 = (i % 2 == 0);
            #1;
            check("t2_if_rdy", 32'(if_req_ready), 32'(e0));
            check("t2_d_rdy", 32'(d_req_ready), 32'(!e0));
            check("t2_rom_a", 32'(rom_a), e0 ? 32'h40 : 32'h80);
            tick();
            check("t2_if_vld", 32'(if_resp_valid), 32'(e0));
            check("t2_d_vld", 32'(d_resp_valid), 32'(!e0));
            if (e0) check("t2_if_dat", if_resp_data, 32'hA500_0040);
            else    check("t2_d_dat", d_resp_data, 32'hA500_0080);
        end

        // Data consumer stalls: only port 0 granted, data held stable
        d_resp_ready = 1'b0;
        for (int j = 0; j < 3; j++) begin
            #1;
            check("t3_if_rdy", 32'(if_req_ready), 1);
            check("t3_d_rdy", 32'(d_req_ready), 0);
            check("t3_d_vld", 32'(d_resp_valid), 1);
            check("t3_d_dat", d_resp_data, 32'hA500_0080);
            tick();
        end
        d_resp_ready = 1'b1;
        #1;
        check("t3_rel_d_rdy", 32'(d_req_ready), 1);
        check("t3_rel_if_rdy", 32'(if_req_ready), 0);
        tick();
        check("t3_rel_d_vld", 32'(d_resp_valid), 1);
        if_req_valid = 1'b0; d_req_valid = 1'b0;
        tick();

        // Error addresses and the last valid word
        if_req_valid = 1'b1;
        for (int e = 0; e < 3; e++) begin
            if_req_addr = err_addrs[e];
            #1;
            check("t4_rdy", 32'(if_req_ready), 1);
            tick();
            check("t4_vld", 32'(if_resp_valid), 1);
            check("t4_err", 32'(if_resp_err), 1);
            check("t4_dat", if_resp_data, 0);
        end
        if_req_addr = 32'h1c3f_fffc;
        #1;
        check("t4_last_rom_a", 32'(rom_a), 32'h000f_ffff);
        tick();
        check("t4_last_err", 32'(if_resp_err), 0);
        check("t4_last_dat", if_resp_data, 32'hA50f_ffff);
        if_req_valid = 1'b0;
        tick();

        // Flush with a held fetch response
        if_resp_ready = 1'b0; if_req_valid = 1'b1; if_req_addr = BASE + 32'h8;
        #1;
        check("t5_pre_rdy", 32'(if_req_ready), 1);
        tick();
        check("t5_pre_vld", 32'(if_resp_valid), 1);
        if_flush = 1'b1; d_req_valid = 1'b1; d_req_addr = BASE + 32'hc;
        #1;
        check("t5_if_rdy", 32'(if_req_ready), 0);
        check("t5_d_rdy", 32'(d_req_ready), 1);
        tick();
        check("t5_if_vld", 32'(if_resp_valid), 0);
        check("t5_d_vld", 32'(d_resp_valid), 1);
        check("t5_d_dat", d_resp_data, 32'hA500_0003);
        if_flush = 1'b0; if_req_valid = 1'b0; d_req_valid = 1'b0; if_resp_ready = 1'b1;
        tick();

        // Reset while both responses are held
        if_resp_ready = 1'b0; d_resp_ready = 1'b0;
        if_req_valid = 1'b1; d_req_valid = 1'b1;
        if_req_addr = BASE + 32'h4; d_req_addr = BASE + 32'h8;
        tick();
        tick();
        check("t6_if_held", 32'(if_resp_valid), 1);
        check("t6_d_held", 32'(d_resp_valid), 1);
        rstn = 1'b0;
        #1;
        check("t6_rst_if_rdy", 32'(if_req_ready), 0);
        check("t6_rst_d_rdy", 32'(d_req_ready), 0);
        tick();
        check("t6_if_vld", 32'(if_resp_valid), 0);
        check("t6_d_vld", 32'(d_resp_valid), 0);
        check("t6_if_dat", if_resp_data, 0);
        check("t6_d_dat", d_resp_data, 0);
        rstn = 1'b1; if_resp_ready = 1'b1; d_resp_ready = 1'b1;
        #1;
        check("t6_tie_if", 32'(if_req_ready), 1);
        check("t6_tie_d", 32'(d_req_ready), 0);
        tick();
        check("t6_post_vld", 32'(if_resp_valid), 1);
        check("t6_post_dat", if_resp_data, 32'hA500_0001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/irom_arbiter.md
# irom_arbiter

Shares the single combinational instruction ROM between two requesters: the fetch port (port 0, IF stage) and the data port (port 1, loads from the text region). Requests are arbitrated round-robin with valid/ready handshakes. The ROM word is captured into a per-port response register with one cycle of latency. The block sits between the core's IF/MEM stages and the ROM instance (word address `a`, data `spo`).

## Interface
Parameters:
- `ADDR_BITS`, 20: ROM word-address width; ROM holds 2**ADDR_BITS 32-bit words.
- `BASE_ADDR`, 32'h1c00_0000: byte address mapped to ROM word 0.

Ports (one clock; reset is synchronous and active-low):
- `clk` in 1: clock, all state updates on rising edge.
- `rstn` in 1: synchronous active-low reset.
- `if_req_valid` in 1: fetch request valid.
- `if_req_ready` out 1: fetch request accepted this cycle.
- `if_req_addr` in 32: fetch byte address.
- `if_resp_valid` out 1: fetch response held.
- `if_resp_ready` in 1: fetch consumer takes response.
- `if_resp_data` out 32: fetched word.
- `if_resp_err` out 1: misaligned or out-of-range address.
- `if_flush` in 1: discard held/accepted fetch response (redirect).
- `d_req_valid`, `d_req_ready`, `d_req_addr`, `d_resp_valid`, `d_resp_ready`, `d_resp_data`, `d_resp_err`: same as fetch port, data side; no flush.
- `rom_a` out ADDR_BITS: ROM word address.
- `rom_spo` in 32: ROM read data (combinational from `rom_a`).

## Operation
- Port p is eligible when `req_valid` is high and its response slot is empty, or is being drained this cycle (`resp_valid && resp_ready`).
- For port 0, the port is also ineligible in any cycle where `if_flush` is high.
- Grant rule:
  - Exactly one port eligible: it wins.
  - Both eligible: the port not granted last wins.
  - The `last` register updates only on an actual grant and resets to 1, so fetch wins the first tie.
- `req_ready` = grant for that port. At most one `req_ready` is high per cycle.
- `rom_a` = (granted addr − BASE_ADDR)[ADDR_BITS+1:2]. With no grant, `rom_a` holds the port-0 mapping (don't-care).
- On grant, the response register loads:
  - `data` = err ? 0 : `rom_spo`.
  - `err` = (addr[1:0] != 0) or (unsigned offset addr − BASE_ADDR ≥ 4·2**ADDR_BITS). Wrap-around below BASE_ADDR is out of range.
  - `resp_valid` set.
- `resp_valid` clears on `resp_ready` when there is no same-cycle grant. Drain plus grant in the same cycle keeps it set with new data.
- `resp_data`/`resp_err` are stable while `resp_valid && !resp_ready`.
- `if_flush`: clears `if_resp_valid` next edge regardless of `if_resp_ready`, and blocks the port-0 grant that cycle. A port-1 grant proceeds normally in a flush cycle.
- Reset clears:
  - all `resp_valid` to 0
  - `resp_data` to 0
  - `resp_err` to 0
  - `last` to 1

  Reset mid-transaction drops all held responses; requests presented during reset get `req_ready` 0.

## Timing
- Request accepted at edge N (valid && ready in cycle N−1); `resp_valid` high in cycle N.
- Latency 1 cycle. Sustained throughput is 1 word per cycle total. Each port sustains 1 per cycle when alone and its consumer holds `resp_ready` high.
- Both ports saturated: grants alternate 0,1,0,1…
- Combinational paths:
  - `req_valid`, `resp_ready`, `if_flush` → `req_ready`.
  - addr → `rom_a`.
  - No path from `rom_spo` to any output except through the response register.

## Structure
- Package `irom_pkg`: `ADDR_BITS` default, `BASE_ADDR`, port index constants `PORT_IF=0`, `PORT_D=1`, and the response struct typedef {valid, err, data}.
- Sub-module `rr_arb2`: 2-way round-robin arbiter (req[1:0], advance → gnt[1:0], `last` register). The rest of the block is datapath and response registers.

## Test plan
- Port 0 only, addr 0x1c00_0000..0x1c00_000c, `resp_ready`=1 → four responses on consecutive cycles, data = ROM words 0..3, err 0.
- Both ports valid continuously, both `resp_ready`=1 → grants alternate starting with port 0; each port gets 1 response per 2 cycles.
- Port 1 `resp_ready`=0 with one response held, both requesting → only port 0 granted. Port 1 data stays stable until `resp_ready` rises, then port 1 is granted that same cycle.
- Addresses 0x1c00_0002 (misaligned), 0x1bff_fffc (below base) and BASE+4·2**20 (beyond end) → err 1, data 0, 1-cycle latency.
- `if_flush` asserted with `if_resp_valid`=1 and port 0 requesting → next cycle `if_resp_valid`=0, no port-0 grant in the flush cycle; port 1 is granted if requesting.
- `rstn`=0 for one cycle while both responses are held → all `resp_valid` 0, data 0; first tie after reset is granted to port 0.
